// File: rtl/wb_buffer_if.sv
// Write-buffer bus: ALU result input, register-file write port and operand forwarding.
interface wb_buffer_if #(
  parameter int unsigned DW = 16,
  parameter int unsigned AW = 4
);
  logic          IN_VALID;
  logic          IN_READY;
  logic          IN_WEN;
  logic [AW-1:0] IN_WADR;
  logic [DW-1:0] IN_DATA;
  logic          RF_STALL;
  logic          WEN;
  logic [AW-1:0] WADR;
  logic [DW-1:0] ALUIN;
  logic [AW-1:0] RADR1;
  logic [AW-1:0] RADR2;
  logic [DW-1:0] RF_OUT1;
  logic [DW-1:0] RF_OUT2;
  logic [DW-1:0] OP1;
  logic [DW-1:0] OP2;
  logic          BUSY;

  modport master (
    output IN_VALID, IN_WEN, IN_WADR, IN_DATA, RF_STALL,
    output RADR1, RADR2, RF_OUT1, RF_OUT2,
    input  IN_READY, WEN, WADR, ALUIN, OP1, OP2, BUSY
  );

  modport slave (
    input  IN_VALID, IN_WEN, IN_WADR, IN_DATA, RF_STALL,
    input  RADR1, RADR2, RF_OUT1, RF_OUT2,
    output IN_READY, WEN, WADR, ALUIN, OP1, OP2, BUSY
  );
endinterface

// File: rtl/wb_buffer.sv
// In-order write-back buffer between ALU and register file, with youngest-entry
// operand forwarding from pending writes.
module wb_buffer #(
  parameter int unsigned DW    = 16,
  parameter int unsigned AW    = 4,
  parameter int unsigned DEPTH = 2
) (
  input logic        clk,
  input logic        rst,
  wb_buffer_if.slave bus
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [AW-1:0] adr_q [DEPTH];
  logic [DW-1:0] dat_q [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;

  logic          nonempty;
  logic          ready;
  logic          push;
  logic          pop;
  logic [DW-1:0] op1;
  logic [DW-1:0] op2;

  // Acceptance depends only on occupancy, so a full buffer refuses even when draining.
  assign nonempty = (count != '0);
  assign ready    = (count < CW'(DEPTH));
  assign pop      = nonempty && !bus.RF_STALL;
  assign push     = bus.IN_VALID && ready && bus.IN_WEN;

  assign bus.IN_READY = ready;
  assign bus.WEN      = pop;
  assign bus.WADR     = nonempty ? adr_q[rd_ptr] : '0;
  assign bus.ALUIN    = nonempty ? dat_q[rd_ptr] : '0;
  assign bus.BUSY     = nonempty;
  assign bus.OP1      = op1;
  assign bus.OP2      = op2;

  // Walk oldest to youngest so the last match wins; the head is included even while popping.
  always_comb begin
    op1 = bus.RF_OUT1;
    op2 = bus.RF_OUT2;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (CW'(i) < count) begin
        if (adr_q[rd_ptr + PW'(i)] == bus.RADR1) op1 = dat_q[rd_ptr + PW'(i)];
        if (adr_q[rd_ptr + PW'(i)] == bus.RADR2) op2 = dat_q[rd_ptr + PW'(i)];
      end
    end
  end

  // Entry storage needs no reset; validity is carried entirely by count and rd_ptr.
  always_ff @(posedge clk) begin
    if (push) begin
      adr_q[wr_ptr] <= bus.IN_WADR;
      dat_q[wr_ptr] <= bus.IN_DATA;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
      if (pop)  rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: tb/tb_wb_buffer.sv
// Directed bench for wb_buffer: queue-based reference model checked every cycle,
// plus hand-computed pinned expectations at key cycles.
module tb_wb_buffer;
  localparam int unsigned DW    = 16;
  localparam int unsigned AW    = 4;
  localparam int unsigned DEPTH = 2;

  typedef struct packed {
    logic [AW-1:0] adr;
    logic [DW-1:0] dat;
  } ent_t;

  logic clk = 1'b0;
  logic rst = 1'b0;

  wb_buffer_if #(.DW(DW), .AW(AW)) bus ();

  wb_buffer #(.DW(DW), .AW(AW), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int unsigned tests = 0;
  int unsigned fails = 0;

  ent_t mq[$];

  // Pinned expectations, written by the stimulus, checked by the compare process.
  logic          pin_en = 1'b0;
  logic          p_ready, p_wen, p_busy;
  logic [AW-1:0] p_wadr;
  logic [DW-1:0] p_aluin, p_op1;

  // Reference model: pending writes as a queue, oldest at the front.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
    end else begin
      bit do_pop;
      bit do_push;
      do_pop  = (mq.size() != 0) && !bus.RF_STALL;
      do_push = bus.IN_VALID && bus.IN_WEN && (mq.size() < DEPTH);
      if (do_pop) void'(mq.pop_front());
      if (do_push) mq.push_back('{adr: bus.IN_WADR, dat: bus.IN_DATA});
    end
  end

  function automatic logic [DW-1:0] fwd(input logic [AW-1:0] a, input logic [DW-1:0] rf);
    for (int i = int'(mq.size()) - 1; i >= 0; i--)
      if (mq[i].adr == a) return mq[i].dat;
    return rf;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s at %0t: got %h want %h", name, $time, got, want);
    end
  endtask

  // Compare process: outputs are stable mid-cycle, away from the active edge.
  always @(negedge clk) begin
    int unsigned n;
    n = mq.size();
    chk("IN_READY", 32'(bus.IN_READY), 32'(n < DEPTH));
    chk("WEN",      32'(bus.WEN),      32'((n != 0) && !bus.RF_STALL));
    chk("WADR",     32'(bus.WADR),     (n != 0) ? 32'(mq[0].adr) : 32'd0);
    chk("ALUIN",    32'(bus.ALUIN),    (n != 0) ? 32'(mq[0].dat) : 32'd0);
    chk("BUSY",     32'(bus.BUSY),     32'(n != 0));
    chk("OP1",      32'(bus.OP1),      32'(fwd(bus.RADR1, bus.RF_OUT1)));
    chk("OP2",      32'(bus.OP2),      32'(fwd(bus.RADR2, bus.RF_OUT2)));
    if (pin_en) begin
      chk("pin_ready", 32'(bus.IN_READY), 32'(p_ready));
      chk("pin_wen",   32'(bus.WEN),      32'(p_wen));
      chk("pin_wadr",  32'(bus.WADR),     32'(p_wadr));
      chk("pin_aluin", 32'(bus.ALUIN),    32'(p_aluin));
      chk("pin_busy",  32'(bus.BUSY),     32'(p_busy));
      chk("pin_op1",   32'(bus.OP1),      32'(p_op1));
    end
  end

  task automatic drive(input logic v, input logic w, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic s);
    bus.IN_VALID = v;
    bus.IN_WEN   = w;
    bus.IN_WADR  = a;
    bus.IN_DATA  = d;
    bus.RF_STALL = s;
  endtask

  task automatic rd(input logic [AW-1:0] a1, input logic [DW-1:0] r1,
                    input logic [AW-1:0] a2, input logic [DW-1:0] r2);
    bus.RADR1   = a1;
    bus.RF_OUT1 = r1;
    bus.RADR2   = a2;
    bus.RF_OUT2 = r2;
  endtask

  task automatic pin(input logic r, input logic w, input logic [AW-1:0] a,
                     input logic [DW-1:0] d, input logic b, input logic [DW-1:0] o1);
    p_ready = r;
    p_wen   = w;
    p_wadr  = a;
    p_aluin = d;
    p_busy  = b;
    p_op1   = o1;
    pin_en  = 1'b1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    pin_en = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, tests %0d", tests);
    $fatal(1, "timeout");
  end

  initial begin
    // Reset: outputs idle, push attempt ignored
    rst = 1'b1;
    drive(1'b0, 1'b0, 4'd0, 16'h0, 1'b0);
    rd(4'd0, 16'h1111, 4'd1, 16'h2222);
    pin(1'b1, 1'b0, 4'd0, 16'h0, 1'b0, 16'h1111);
    tick();
    drive(1'b1, 1'b1, 4'd0, 16'h9999, 1'b0);
    pin(1'b1, 1'b0, 4'd0, 16'h0, 1'b0, 16'h1111);
    tick();
    rst = 1'b0;

    // Single write R3=0x1234, forwarded while being written
    drive(1'b1, 1'b1, 4'd3, 16'h1234, 1'b0);
    rd(4'd3, 16'hFFFF, 4'd0, 16'h0000);
    pin(1'b1, 1'b0, 4'd0, 16'h0, 1'b0, 16'hFFFF);
    tick();
    drive(1'b0, 1'b0, 4'd0, 16'h0, 1'b0);
    pin(1'b1, 1'b1, 4'd3, 16'h1234, 1'b1, 16'h1234);
    tick();
    pin(1'b1, 1'b0, 4'd0, 16'h0, 1'b0, 16'hFFFF);
    tick();

    // Stall fills buffer, third push refused, drain in order
    rd(4'd2, 16'h5555, 4'd1, 16'h0F0F);
    drive(1'b1, 1'b1, 4'd1, 16'hAAAA, 1'b1);
    pin(1'b1, 1'b0, 4'd0, 16'h0, 1'b0, 16'h5555);
    tick();
    drive(1'b1, 1'b1, 4'd2, 16'hBBBB, 1'b1);
    pin(1'b1, 1'b0, 4'd1, 16'hAAAA, 1'b1, 16'h5555);
    tick();
    drive(1'b1, 1'b1, 4'd9, 16'hCCCC, 1'b1);
    pin(1'b0, 1'b0, 4'd1, 16'hAAAA, 1'b1, 16'hBBBB);
    tick();
    drive(1'b0, 1'b0, 4'd0, 16'h0, 1'b0);
    pin(1'b0, 1'b1, 4'd1, 16'hAAAA, 1'b1, 16'hBBBB);
    tick();
    pin(1'b1, 1'b1, 4'd2, 16'hBBBB, 1'b1, 16'hBBBB);
    tick();
    pin(1'b1, 1'b0, 4'd0, 16'h0, 1'b0, 16'h5555);
    tick();

    // Youngest of two same-address entries forwards
    rd(4'd5, 16'hFFFF, 4'd0, 16'h0000);
    drive(1'b1, 1'b1, 4'd5, 16'h0001, 1'b1);
    pin(1'b1, 1'b0, 4'd0, 16'h0, 1'b0, 16'hFFFF);
    tick();
    drive(1'b1, 1'b1, 4'd5, 16'h0002, 1'b1);
    pin(1'b1, 1'b0, 4'd5, 16'h0001, 1'b1, 16'h0001);
    tick();
    drive(1'b0, 1'b0, 4'd0, 16'h0, 1'b1);
    pin(1'b0, 1'b0, 4'd5, 16'h0001, 1'b1, 16'h0002);
    tick();
    drive(1'b0, 1'b0, 4'd0, 16'h0, 1'b0);
    pin(1'b0, 1'b1, 4'd5, 16'h0001, 1'b1, 16'h0002);
    tick();
    pin(1'b1, 1'b1, 4'd5, 16'h0002, 1'b1, 16'h0002);
    tick();
    pin(1'b1, 1'b0, 4'd0, 16'h0, 1'b0, 16'hFFFF);
    tick();

    // Full with pop and valid input: pop only, count drops to one
    rd(4'd7, 16'h3333, 4'd4, 16'h4040);
    drive(1'b1, 1'b1, 4'd4, 16'h4444, 1'b1);
    tick();
    drive(1'b1, 1'b1, 4'd6, 16'h6666, 1'b1);
    tick();
    drive(1'b1, 1'b1, 4'd7, 16'h7777, 1'b0);
    pin(1'b0, 1'b1, 4'd4, 16'h4444, 1'b1, 16'h3333);
    tick();
    drive(1'b0, 1'b0, 4'd0, 16'h0, 1'b1);
    pin(1'b1, 1'b0, 4'd6, 16'h6666, 1'b1, 16'h3333);
    tick();
    drive(1'b0, 1'b0, 4'd0, 16'h0, 1'b0);
    pin(1'b1, 1'b1, 4'd6, 16'h6666, 1'b1, 16'h3333);
    tick();
    pin(1'b1, 1'b0, 4'd0, 16'h0, 1'b0, 16'h3333);
    tick();

    // Non-writing result: accepted and dropped
    rd(4'd8, 16'h8888, 4'd0, 16'h0000);
    drive(1'b1, 1'b0, 4'd8, 16'hDEAD, 1'b0);
    pin(1'b1, 1'b0, 4'd0, 16'h0, 1'b0, 16'h8888);
    tick();
    drive(1'b0, 1'b0, 4'd0, 16'h0, 1'b0);
    pin(1'b1, 1'b0, 4'd0, 16'h0, 1'b0, 16'h8888);
    tick();

    // Asynchronous reset with two writes pending
    rd(4'd10, 16'h1010, 4'd11, 16'h1111);
    drive(1'b1, 1'b1, 4'd10, 16'h0A0A, 1'b1);
    tick();
    drive(1'b1, 1'b1, 4'd11, 16'h0B0B, 1'b1);
    tick();
    drive(1'b0, 1'b0, 4'd0, 16'h0, 1'b0);
    #2 rst = 1'b1;
    pin(1'b1, 1'b0, 4'd0, 16'h0, 1'b0, 16'h1010);
    tick();
    rst = 1'b0;
    pin(1'b1, 1'b0, 4'd0, 16'h0, 1'b0, 16'h1010);
    tick();
    tick();

    // Mixed traffic pattern exercising pointer wrap, checked by the model
    for (int i = 0; i < 40; i++) begin
      drive(logic'(i % 3 != 2), logic'(i % 5 != 4), AW'(i % 16),
            DW'(32'h0111 * 32'(i) + 32'h5), logic'(i % 4 == 1 || i % 7 == 3));
      rd(AW'((i + 15) % 16), DW'(32'hF000 + 32'(i)), AW'((i + 14) % 16), DW'(32'hE000 + 32'(i)));
      tick();
    end
    drive(1'b0, 1'b0, 4'd0, 16'h0, 1'b0);
    tick();
    tick();
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/wb_buffer.md
WB_BUFFER -- requirements
Module: wb_buffer

Interface
REQ-001 SHALL have parameter DW, default 16, data width of the register-file write port.
REQ-002 SHALL have parameter AW, default 4, register address width (16 registers).
REQ-003 SHALL have parameter DEPTH, default 2, number of pending-write entries (power of two, >= 2).
REQ-004 SHALL have port clk  input  1  single clock; all state updates on posedge clk.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port IN_VALID  input  1  upstream ALU result valid.
REQ-007 SHALL have port IN_READY  output  1  buffer can accept a result this cycle.
REQ-008 SHALL have port IN_WEN  input  1  result is to be written to a register.
REQ-009 SHALL have port IN_WADR  input  AW  destination register.
REQ-010 SHALL have port IN_DATA  input  DW  ALU result.
REQ-011 SHALL have port RF_STALL  input  1  register-file write port unavailable this cycle.
REQ-012 SHALL have port WEN  output  1  register-file write enable.
REQ-013 SHALL have port WADR  output  AW  register-file write address.
REQ-014 SHALL have port ALUIN  output  DW  register-file write data.
REQ-015 SHALL have ports RADR1, RADR2  input  AW each  operand read addresses (also driven to the register file).
REQ-016 SHALL have ports RF_OUT1, RF_OUT2  input  DW each  combinational register-file read data.
REQ-017 SHALL have ports OP1, OP2  output  DW each  forwarded operands.
REQ-018 SHALL have port BUSY  output  1  at least one write pending.

Function
REQ-019 SHALL hold an in-order FIFO of DEPTH entries {WADR, DATA} plus an occupancy count 0..DEPTH.
REQ-020 IN_READY SHALL equal (count < DEPTH), depending only on registered state, never on IN_VALID or RF_STALL.
REQ-021 A transfer SHALL occur when IN_VALID && IN_READY; if IN_WEN=1 the entry is pushed at the next posedge, if IN_WEN=0 it is accepted and dropped.
REQ-022 WEN SHALL equal (count != 0) && !RF_STALL; WADR/ALUIN SHALL always show the head entry (0 when empty).
REQ-023 When WEN=1 the head entry SHALL be popped at the same posedge the register file captures it.
REQ-024 Push and pop in one cycle SHALL leave count unchanged and preserve order; when full, no push occurs even if a pop occurs that cycle.
REQ-025 Writes SHALL reach the register file in acceptance order, one per cycle maximum; zero-cycle minimum latency is not provided (accepted result earliest drives WEN the next cycle).
REQ-026 OPn SHALL equal the data of the youngest valid entry whose address equals RADRn, else RF_OUTn; the head entry being written this cycle is included.
REQ-027 Forwarding SHALL be purely combinational; the incoming IN_DATA of the current cycle SHALL NOT be forwarded.
REQ-028 Register 0 SHALL have no special treatment.
REQ-029 BUSY SHALL equal (count != 0).
REQ-030 Pointers SHALL wrap modulo DEPTH with no lost or duplicated entries.

Reset
REQ-031 While rst=1: count=0, pointers=0, all entries invalid; outputs IN_READY=1, WEN=0, WADR=0, ALUIN=0, BUSY=0, OPn=RF_OUTn.
REQ-032 Reset asserted mid-operation SHALL discard all pending writes immediately (asynchronously), with no register-file write issued afterwards.

Verification
REQ-033 Push {R3,0x1234}, RF_STALL=0 -> next cycle WEN=1, WADR=3, ALUIN=0x1234; following cycle BUSY=0.
REQ-034 RF_STALL=1, push {R1,0xAAAA},{R2,0xBBBB} -> IN_READY=0, third push not accepted; release stall -> writes R1 then R2 on consecutive cycles, IN_READY=1 after first pop.
REQ-035 Pending {R5,0x0001} then {R5,0x0002}, RADR1=5, RF_OUT1=0xFFFF -> OP1=0x0002; after both drain OP1=RF_OUT1.
REQ-036 Full buffer, RF_STALL=0, IN_VALID=1 -> one pop, no push that cycle; count=1 next cycle.
REQ-037 IN_WEN=0 with IN_VALID=1 -> accepted, no WEN pulse, BUSY stays 0.
REQ-038 Two entries pending, assert rst between edges -> WEN=0 immediately, BUSY=0, no write after rst release.
